// File: rtl/trivium_stream_decryptor.sv
// rtl/trivium_stream_decryptor.sv - Trivium stream decryptor (XOR keystream onto a ready/valid stream)
// Optional feature macro: TRIVIUM_DEC_BEATCNT_EN (adds beat_cnt output)
module trivium_stream_decryptor #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [79:0]       key,
  input  logic [79:0]       iv,
  output logic              busy,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data
`ifdef TRIVIUM_DEC_BEATCNT_EN
  ,
  output logic [31:0]       beat_cnt
`endif
);

  // Warm-up is 1152 rounds, DATA_W of them per clock.
  localparam int WARM_CYC = 1152 / DATA_W;
  localparam int CNT_W    = $clog2(WARM_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WARM_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WARM = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Cipher state: st[i-1] holds Trivium bit s_i (s1 at bit 0, s288 at bit 287).
  logic [287:0]       st;
  logic [287:0]       st_adv;
  logic [287:0]       st_load;
  logic [DATA_W-1:0]  ks;
  logic [CNT_W-1:0]   cnt;
  logic               accept;

  // One Trivium round: returns {z, next state}.
  function automatic logic [288:0] trivium_round(input logic [287:0] s);
    logic t1, t2, t3, z;
    t1 = s[65]  ^ s[92];
    t2 = s[161] ^ s[176];
    t3 = s[242] ^ s[287];
    z  = t1 ^ t2 ^ t3;
    t1 = t1 ^ (s[90]  & s[91])  ^ s[170];
    t2 = t2 ^ (s[174] & s[175]) ^ s[263];
    t3 = t3 ^ (s[285] & s[286]) ^ s[68];
    // s1..93 <= t3,s1..92 ; s94..177 <= t2,s94..176 ; s178..288 <= t1,s178..287
    return {z, s[286:177], t1, s[175:93], t2, s[91:0], t3};
  endfunction

  // Initial state image built from key/iv; the top three bits are the fixed ones.
  assign st_load = {3'b111, 112'd0, iv, 13'd0, key};

  // Unrolled DATA_W rounds; ks[j] is the keystream bit of round j (LSB earliest).
  always_comb begin
    logic [288:0] r;
    st_adv = st;
    ks     = '0;
    r      = '0;
    for (int j = 0; j < DATA_W; j++) begin
      r      = trivium_round(st_adv);
      ks[j]  = r[288];
      st_adv = r[287:0];
    end
  end

  // Beats are taken only while running and never on a restart cycle.
  assign s_ready = (state == ST_RUN) && !start && (!m_valid || m_ready);
  assign accept  = s_valid && s_ready;
  assign busy    = (state == ST_WARM);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: start always wins and (re)enters warm-up.
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = ST_WARM;
    end else begin
      case (state)
        ST_WARM: if (cnt == CNT_LAST) state_nxt = ST_RUN;
        default: state_nxt = state;
      endcase
    end
  end

  // Cipher state, warm-up counter and output beat register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st      <= '0;
      cnt     <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (start) begin
      st      <= st_load;
      cnt     <= '0;
      m_valid <= 1'b0;
    end else begin
      case (state)
        ST_WARM: begin
          st  <= st_adv;
          cnt <= cnt + 1'b1;
        end
        ST_RUN: begin
          if (accept) begin
            st      <= st_adv;
            m_data  <= s_data ^ ks;
            m_valid <= 1'b1;
          end else if (m_ready) begin
            m_valid <= 1'b0;
          end
        end
        default: begin
          m_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef TRIVIUM_DEC_BEATCNT_EN
  // Count of accepted input beats since the last start; wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt <= '0;
    end else if (start) begin
      beat_cnt <= '0;
    end else if (accept) begin
      beat_cnt <= beat_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_trivium_stream_decryptor.sv
// tb/tb_trivium_stream_decryptor.sv - self-checking bench for trivium_stream_decryptor
module tb_trivium_stream_decryptor;

  localparam int DATA_W = 8;
  localparam int WARM   = 1152 / DATA_W;

  logic              clk;
  logic              rst;
  logic              start;
  logic [79:0]       key;
  logic [79:0]       iv;
  logic              busy;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
`ifdef TRIVIUM_DEC_BEATCNT_EN
  logic [31:0]       beat_cnt;
`endif

  trivium_stream_decryptor #(.DATA_W(DATA_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .key     (key),
    .iv      (iv),
    .busy    (busy),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data)
`ifdef TRIVIUM_DEC_BEATCNT_EN
    ,
    .beat_cnt(beat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: Trivium state as bits s[1..288], stepped one round at a time.
  bit ms [1:288];

  function automatic bit model_round();
    bit t1, t2, t3, z;
    t1 = ms[66]  ^ ms[93];
    t2 = ms[162] ^ ms[177];
    t3 = ms[243] ^ ms[288];
    z  = t1 ^ t2 ^ t3;
    t1 = t1 ^ (ms[91]  & ms[92])  ^ ms[171];
    t2 = t2 ^ (ms[175] & ms[176]) ^ ms[264];
    t3 = t3 ^ (ms[286] & ms[287]) ^ ms[69];
    for (int i = 93; i > 1; i--)    ms[i] = ms[i-1];
    ms[1] = t3;
    for (int i = 177; i > 94; i--)  ms[i] = ms[i-1];
    ms[94] = t2;
    for (int i = 288; i > 178; i--) ms[i] = ms[i-1];
    ms[178] = t1;
    return z;
  endfunction

  function automatic void model_load(input logic [79:0] k, input logic [79:0] v);
    bit z;
    for (int i = 1; i <= 288; i++) ms[i] = 1'b0;
    for (int i = 0; i < 80; i++) begin
      ms[1 + i]  = k[i];
      ms[94 + i] = v[i];
    end
    ms[286] = 1'b1; ms[287] = 1'b1; ms[288] = 1'b1;
    for (int i = 0; i < 1152; i++) z = model_round();
  endfunction

  function automatic logic [DATA_W-1:0] model_word();
    logic [DATA_W-1:0] w;
    for (int j = 0; j < DATA_W; j++) w[j] = model_round();
    return w;
  endfunction

  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] din   [$];
  logic [DATA_W-1:0] dout  [$];
  logic [DATA_W-1:0] t3_out[$];
  logic [DATA_W-1:0] ct    [$];
  int   last_cycles;
  bit   hold_prev;
  logic [DATA_W-1:0] hold_md;

  // One clock: drive at negedge, sample just after, scoreboard the handshakes.
  task automatic cyc(input logic sv, input logic [DATA_W-1:0] sd, input logic mr, input logic st,
                     output logic acs, output logic acm, output logic [DATA_W-1:0] md);
    start = st; s_valid = sv; s_data = sd; m_ready = mr;
    #1;
    if (hold_prev) begin
      check("hold_valid", m_valid, 1'b1);
      check("hold_data", m_data, hold_md);
    end
    acs = s_valid & s_ready;
    acm = m_valid & m_ready & !st;
    md  = m_data;
    if (acm) begin
      if (exp_q.size() == 0) check("unexpected_out", 1'b1, 1'b0);
      else check("m_data", md, exp_q.pop_front());
    end
    if (acs) exp_q.push_back(sd ^ model_word());
    if (st) begin
      exp_q.delete();
      model_load(key, iv);
    end
    hold_prev = m_valid & !m_ready & !st;
    hold_md   = m_data;
    @(negedge clk);
  endtask

  task automatic pulse_start(input logic [79:0] k, input logic [79:0] v);
    logic a, b; logic [DATA_W-1:0] d;
    key = k; iv = v;
    cyc(1'b0, '0, 1'b0, 1'b1, a, b, d);
    check("busy_after_start", busy, 1'b1);
  endtask

  task automatic wait_warm();
    logic a, b; logic [DATA_W-1:0] d;
    int n;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      cyc(1'b0, '0, 1'b0, 1'b0, a, b, d);
      n++;
    end
    check("busy_cycles", n, WARM);
    check("s_ready_after_warm", s_ready, 1'b1);
  endtask

  // Send din[0..n-1]; pv/pr are percent chances of s_valid / m_ready per cycle.
  task automatic feed(input int n, input int pv, input int pr);
    int sent, got, nc;
    logic acs, acm, sv, mr;
    logic [DATA_W-1:0] md;
    dout.delete();
    sent = 0; got = 0; nc = 0;
    while (got < n && nc < 40 * n + 100) begin
      sv = (sent < n) && ($urandom_range(99) < pv);
      mr = ($urandom_range(99) < pr);
      cyc(sv, sv ? din[sent] : DATA_W'($urandom), mr, 1'b0, acs, acm, md);
      if (acs) sent++;
      if (acm) begin
        dout.push_back(md);
        got++;
      end
      nc++;
    end
    check("feed_count", got, n);
    last_cycles = nc;
  endtask

  logic [79:0] key0, iv0;

  initial begin
    logic a, b;
    logic [DATA_W-1:0] d, frozen;
    key0 = 80'hC653219648_4E82B72473;
    iv0  = 80'hF35295A3BD_0235971F25;
    hold_prev = 0;
    rst = 1'b0; start = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0; key = '0; iv = '0;

    // Test 1: reset held with random inputs
    for (int i = 0; i < 6; i++) begin
      start = 1'($urandom); s_valid = 1'($urandom); m_ready = 1'($urandom);
      s_data = DATA_W'($urandom); key = {16'($urandom), 32'($urandom), 32'($urandom)}; iv = key ^ 80'h5;
      @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_s_ready", s_ready, 1'b0);
      check("rst_m_valid", m_valid, 1'b0);
      check("rst_m_data", m_data, '0);
    end
    start = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 1'b0);
    check("idle_s_ready", s_ready, 1'b0);

    // Test 2: warm-up latency
    pulse_start(key0, iv0);
    wait_warm();

    // Test 3: 64 zero beats at full throughput
    din.delete();
    for (int i = 0; i < 64; i++) din.push_back('0);
    feed(64, 100, 100);
    check("throughput_cycles", last_cycles, 65);
    t3_out = dout;

    // Test 4: round trip
    pulse_start(key0, iv0);
    wait_warm();
    din.delete();
    for (int i = 0; i < 64; i++) din.push_back(DATA_W'(i));
    feed(64, 100, 100);
    ct = dout;
    pulse_start(key0, iv0);
    wait_warm();
    din = ct;
    feed(64, 100, 100);
    for (int i = 0; i < 64; i++) check("roundtrip", dout[i], DATA_W'(i));

    // Test 5: backpressure stall, then continue
    for (int i = 0; i < 3; i++) cyc(1'b1, DATA_W'($urandom), 1'b1, 1'b0, a, b, d);
    frozen = m_data;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, DATA_W'($urandom), 1'b0, 1'b0, a, b, d);
      check("stall_s_ready", a, 1'b0);
      check("stall_m_data", d, frozen);
    end
    din.delete();
    for (int i = 0; i < 20; i++) din.push_back(DATA_W'($urandom));
    feed(20, 100, 100);

    // Test 6: restart after beat 10
    pulse_start(key0, iv0);
    wait_warm();
    for (int i = 0; i < 10; i++) cyc(1'b1, DATA_W'($urandom), 1'b1, 1'b0, a, b, d);
`ifdef TRIVIUM_DEC_BEATCNT_EN
    check("beat_cnt_10", beat_cnt, 32'd10);
`endif
    cyc(1'b1, DATA_W'($urandom), 1'b0, 1'b1, a, b, d);
    check("restart_no_accept", a, 1'b0);
    check("restart_m_valid", m_valid, 1'b0);
    check("restart_busy", busy, 1'b1);
`ifdef TRIVIUM_DEC_BEATCNT_EN
    check("beat_cnt_clr", beat_cnt, 32'd0);
`endif
    wait_warm();
    din.delete();
    for (int i = 0; i < 64; i++) din.push_back('0);
    feed(64, 100, 100);
    for (int i = 0; i < 64; i++) check("restart_stream", dout[i], t3_out[i]);

    // Randomized traffic with a random key/iv
    pulse_start({16'($urandom), 32'($urandom), 32'($urandom)}, {16'($urandom), 32'($urandom), 32'($urandom)});
    wait_warm();
    din.delete();
    for (int i = 0; i < 200; i++) din.push_back(DATA_W'($urandom));
    feed(200, 60, 60);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) cyc(1'b1, DATA_W'($urandom), 1'b0, 1'b0, a, b, d);
    #2 rst = 1'b0;
    #1;
    check("async_busy", busy, 1'b0);
    check("async_s_ready", s_ready, 1'b0);
    check("async_m_valid", m_valid, 1'b0);
    check("async_m_data", m_data, '0);
    hold_prev = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_idle", s_ready, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
